// File: rtl/pong_game_fsm_pkg.sv
// Shared encodings for the Pong engine: FSM state codes, winner codes, keypad codes
// and the five-zone bounce velocity table.
package pong_game_fsm_pkg;

  // state | meaning: IDLE waiting for start, SERVE ball held on server paddle,
  // PLAY ball in flight, PAUSE frozen awaiting resume, POINT freeze after a miss, GAME_OVER final.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_PAUSE     = 3'd3;
  localparam logic [2:0] ST_POINT     = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [3:0] KEY_UP   = 4'd2;
  localparam logic [3:0] KEY_DOWN = 4'd8;

  typedef enum logic [1:0] {
    VDIR_KEEP = 2'd0,
    VDIR_UP   = 2'd1,
    VDIR_DOWN = 2'd2
  } vdir_t;

  typedef struct packed {
    logic [2:0] dx;
    logic [2:0] dy;
    vdir_t      vdir;
  } zone_vel_t;

  function automatic zone_vel_t zone_lookup(input logic [2:0] zone);
    zone_vel_t zv;
    case (zone)
      3'd0:    zv = '{dx: 3'd2, dy: 3'd2, vdir: VDIR_UP};
      3'd1:    zv = '{dx: 3'd3, dy: 3'd1, vdir: VDIR_UP};
      3'd3:    zv = '{dx: 3'd3, dy: 3'd1, vdir: VDIR_DOWN};
      3'd4:    zv = '{dx: 3'd2, dy: 3'd2, vdir: VDIR_DOWN};
      default: zv = '{dx: 3'd4, dy: 3'd0, vdir: VDIR_KEEP};
    endcase
    return zv;
  endfunction

endpackage

// File: rtl/pong_game_fsm_paddle_ctrl.sv
// One paddle: moves by PADDLE_SPEED on enabled cycles, clamped to the playfield.
// The next-position output lets the serving ball follow the paddle in the same tick.
module pong_game_fsm_paddle_ctrl
  import pong_game_fsm_pkg::*;
#(
  parameter int FRAME_H      = 480,
  parameter int PADDLE_H     = 60,
  parameter int PADDLE_SPEED = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [3:0]  keys,
  output logic [11:0] paddle_y,
  output logic [11:0] paddle_y_next
);

  localparam logic [11:0] Y_MAX = 12'(FRAME_H - PADDLE_H);
  localparam logic [11:0] Y_RST = 12'((FRAME_H - PADDLE_H) / 2);
  localparam logic [11:0] STEP  = 12'(PADDLE_SPEED);

  logic [11:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (en) begin
      if (keys == KEY_UP) begin
        y_d = (y_q < STEP) ? 12'd0 : y_q - STEP;
      end else if (keys == KEY_DOWN) begin
        y_d = (y_q > Y_MAX - STEP) ? Y_MAX : y_q + STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) y_q <= Y_RST;
    else          y_q <= y_d;
  end

  assign paddle_y      = y_q;
  assign paddle_y_next = y_d;

endmodule

// File: rtl/pong_game_fsm.sv
// Pong engine: ball flight, wall and five-zone paddle bounces, scoring, serve/point
// delays, pause and game-over. Motion advances on tick; start and pause act on any cycle.
module pong_game_fsm
  import pong_game_fsm_pkg::*;
#(
  parameter int FRAME_W      = 640,
  parameter int FRAME_H      = 480,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 60,
  parameter int BALL_SIZE    = 8,
  parameter int P1_X         = 16,
  parameter int P2_X         = 616,
  parameter int PADDLE_SPEED = 4,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_TICKS  = 60,
  parameter int POINT_TICKS  = 30
) (
  input  logic               CLOCK_25,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               start,
  input  logic               pause,
  input  logic [3:0]         keys_1,
  input  logic [3:0]         keys_2,
  output logic [11:0]        ball_x,
  output logic [11:0]        ball_y,
  output logic [11:0]        paddle_1_y,
  output logic [11:0]        paddle_2_y,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [2:0]         state,
  output logic [1:0]         winner,
  output logic               point
);

  localparam logic signed [12:0] FACE_L    = 13'(P1_X + PADDLE_W);
  localparam logic signed [12:0] FACE_R    = 13'(P2_X - BALL_SIZE);
  localparam logic signed [12:0] BALL_YMAX = 13'(FRAME_H - BALL_SIZE);
  localparam logic signed [12:0] BALL_S    = 13'(BALL_SIZE);
  localparam logic signed [12:0] BALL_HALF = 13'(BALL_SIZE / 2);
  localparam logic signed [12:0] PAD_H     = 13'(PADDLE_H);
  localparam logic signed [12:0] BAND1     = 13'(PADDLE_H / 5);
  localparam logic signed [12:0] BAND2     = 13'(2 * (PADDLE_H / 5));
  localparam logic signed [12:0] BAND3     = 13'(3 * (PADDLE_H / 5));
  localparam logic signed [12:0] BAND4     = 13'(4 * (PADDLE_H / 5));
  localparam logic [11:0] SERVE_X_P1 = 12'(P1_X + PADDLE_W + 1);
  localparam logic [11:0] SERVE_X_P2 = 12'(P2_X - BALL_SIZE - 1);
  localparam logic [11:0] SERVE_OFS  = 12'(PADDLE_H / 2 - BALL_SIZE / 2);
  localparam logic [11:0] BALL_X_RST = 12'((FRAME_W - BALL_SIZE) / 2);
  localparam logic [11:0] BALL_Y_RST = 12'((FRAME_H - BALL_SIZE) / 2);
  localparam logic [15:0] SERVE_T    = 16'(SERVE_TICKS);
  localparam logic [15:0] POINT_T    = 16'(POINT_TICKS);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

  logic [2:0]         state_q, state_d, saved_q, saved_d;
  logic [11:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [2:0]         dx_q, dx_d, dy_q, dy_d;
  logic               dir_r_q, dir_r_d, dir_d_q, dir_d_d;
  logic               server_q, server_d;
  logic [15:0]        timer_q, timer_d;
  logic [SCORE_W-1:0] score_1_q, score_1_d, score_2_q, score_2_d;
  logic [1:0]         winner_q, winner_d;
  logic               point_q, point_d;

  logic        paddle_en;
  logic [11:0] p1_y, p1_y_nx, p2_y, p2_y_nx;
  logic [11:0] serve_x, serve_y_now, serve_y_next;

  assign paddle_en = tick && !start && !pause && (state_q == ST_SERVE || state_q == ST_PLAY);

  pong_game_fsm_paddle_ctrl #(
    .FRAME_H(FRAME_H), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)
  ) u_paddle_1 (
    .clk(CLOCK_25), .reset_n(reset_n), .en(paddle_en), .keys(keys_1),
    .paddle_y(p1_y), .paddle_y_next(p1_y_nx)
  );

  pong_game_fsm_paddle_ctrl #(
    .FRAME_H(FRAME_H), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)
  ) u_paddle_2 (
    .clk(CLOCK_25), .reset_n(reset_n), .en(paddle_en), .keys(keys_2),
    .paddle_y(p2_y), .paddle_y_next(p2_y_nx)
  );

  assign serve_x      = server_q ? SERVE_X_P2 : SERVE_X_P1;
  assign serve_y_now  = (server_q ? p2_y : p1_y) + SERVE_OFS;
  assign serve_y_next = (server_q ? p2_y_nx : p1_y_nx) + SERVE_OFS;

  // Ball step in 13-bit signed so a move past the top wall shows up as negative.
  logic signed [12:0] dx_s, dy_s, nx, ny, ny_c, pad_top, ctr_ofs;
  logic               wall_dir, cross_l, cross_r, overlap;
  logic [2:0]         zone;
  zone_vel_t          zv;

  assign dx_s = $signed({10'd0, dx_q});
  assign dy_s = $signed({10'd0, dy_q});

  always_comb begin
    nx = $signed({1'b0, ball_x_q}) + (dir_r_q ? dx_s : -dx_s);
    ny = $signed({1'b0, ball_y_q}) + (dir_d_q ? dy_s : -dy_s);
    ny_c     = ny;
    wall_dir = dir_d_q;
    if (ny < 13'sd0) begin
      ny_c     = 13'sd0;
      wall_dir = 1'b1;
    end else if (ny > BALL_YMAX) begin
      ny_c     = BALL_YMAX;
      wall_dir = 1'b0;
    end
    cross_l = !dir_r_q && (nx <= FACE_L);
    cross_r = dir_r_q && (nx >= FACE_R);
    pad_top = $signed({1'b0, cross_l ? p1_y : p2_y});
    overlap = (ny_c + BALL_S > pad_top) && (ny_c < pad_top + PAD_H);
    ctr_ofs = ny_c + BALL_HALF - pad_top;
    if      (ctr_ofs < BAND1) zone = 3'd0;
    else if (ctr_ofs < BAND2) zone = 3'd1;
    else if (ctr_ofs < BAND3) zone = 3'd2;
    else if (ctr_ofs < BAND4) zone = 3'd3;
    else                      zone = 3'd4;
    zv = zone_lookup(zone);
  end

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    dir_r_d   = dir_r_q;
    dir_d_d   = dir_d_q;
    server_d  = server_q;
    timer_d   = timer_q;
    score_1_d = score_1_q;
    score_2_d = score_2_q;
    winner_d  = winner_q;
    point_d   = 1'b0;
    if (start) begin
      state_d   = ST_SERVE;
      timer_d   = SERVE_T;
      score_1_d = '0;
      score_2_d = '0;
      winner_d  = WIN_NONE;
      server_d  = 1'b0;
      ball_x_d  = SERVE_X_P1;
      ball_y_d  = p1_y + SERVE_OFS;
    end else if (pause && (state_q == ST_SERVE || state_q == ST_PLAY)) begin
      saved_d = state_q;
      state_d = ST_PAUSE;
    end else if (pause && state_q == ST_PAUSE) begin
      state_d = saved_q;
    end else if (tick) begin
      case (state_q)
        ST_SERVE: begin
          ball_x_d = serve_x;
          ball_y_d = serve_y_next;
          if (timer_q <= 16'd1) begin
            timer_d = '0;
            state_d = ST_PLAY;
            dx_d    = 3'd4;
            dy_d    = 3'd0;
            dir_r_d = !server_q;
            dir_d_d = 1'b0;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        ST_PLAY: begin
          ball_y_d = ny_c[11:0];
          dir_d_d  = wall_dir;
          ball_x_d = nx[11:0];
          if ((cross_l || cross_r) && overlap) begin
            ball_x_d = cross_l ? FACE_L[11:0] : FACE_R[11:0];
            dir_r_d  = cross_l;
            dx_d     = zv.dx;
            dy_d     = zv.dy;
            if (zv.vdir == VDIR_UP)        dir_d_d = 1'b0;
            else if (zv.vdir == VDIR_DOWN) dir_d_d = 1'b1;
          end else if (cross_l || cross_r) begin
            point_d = 1'b1;
            state_d = ST_POINT;
            timer_d = POINT_T;
            if (cross_l) begin
              if (score_2_q < WIN) score_2_d = score_2_q + ONE;
              server_d = 1'b0;
            end else begin
              if (score_1_q < WIN) score_1_d = score_1_q + ONE;
              server_d = 1'b1;
            end
          end
        end
        ST_POINT: begin
          if (timer_q <= 16'd1) begin
            timer_d = '0;
            if (score_1_q == WIN) begin
              state_d  = ST_GAME_OVER;
              winner_d = WIN_P1;
            end else if (score_2_q == WIN) begin
              state_d  = ST_GAME_OVER;
              winner_d = WIN_P2;
            end else begin
              state_d  = ST_SERVE;
              timer_d  = SERVE_T;
              ball_x_d = serve_x;
              ball_y_d = serve_y_now;
            end
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      saved_q   <= ST_IDLE;
      ball_x_q  <= BALL_X_RST;
      ball_y_q  <= BALL_Y_RST;
      dx_q      <= 3'd4;
      dy_q      <= 3'd0;
      dir_r_q   <= 1'b1;
      dir_d_q   <= 1'b0;
      server_q  <= 1'b0;
      timer_q   <= '0;
      score_1_q <= '0;
      score_2_q <= '0;
      winner_q  <= WIN_NONE;
      point_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      dir_r_q   <= dir_r_d;
      dir_d_q   <= dir_d_d;
      server_q  <= server_d;
      timer_q   <= timer_d;
      score_1_q <= score_1_d;
      score_2_q <= score_2_d;
      winner_q  <= winner_d;
      point_q   <= point_d;
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign paddle_1_y = p1_y;
  assign paddle_2_y = p2_y;
  assign score_1    = score_1_q;
  assign score_2    = score_2_q;
  assign state      = state_q;
  assign winner     = winner_q;
  assign point      = point_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// Bench for pong_game_fsm: directed scenarios plus a randomized full game, every cycle
// compared against a behavioural game model.
module tb_pong_game_fsm;
  import pong_game_fsm_pkg::*;

  logic        CLOCK_25 = 1'b0;
  logic        reset_n, tick, start, pause;
  logic [3:0]  keys_1, keys_2;
  logic [11:0] ball_x, ball_y, paddle_1_y, paddle_2_y;
  logic [3:0]  score_1, score_2;
  logic [2:0]  state;
  logic [1:0]  winner;
  logic        point;

  int checks = 0;
  int errors = 0;

  always #20 CLOCK_25 = ~CLOCK_25;

  pong_game_fsm dut (
    .CLOCK_25(CLOCK_25), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause),
    .keys_1(keys_1), .keys_2(keys_2), .ball_x(ball_x), .ball_y(ball_y),
    .paddle_1_y(paddle_1_y), .paddle_2_y(paddle_2_y), .score_1(score_1), .score_2(score_2),
    .state(state), .winner(winner), .point(point)
  );

  typedef enum int {M_IDLE, M_SERVE, M_PLAY, M_PAUSE, M_POINT, M_OVER} mstate_t;
  mstate_t mst, msaved;
  int mbx, mby, mp1, mp2, ms1, ms2, mwin, mpt, mdx, mdy, mserver, mtimer;
  bit mright, mdown;
  int zdx[5] = '{2, 3, 4, 3, 2};
  int zdy[5] = '{2, 1, 0, 1, 2};

  function automatic logic [2:0] st_code(input mstate_t s);
    case (s)
      M_IDLE:  return ST_IDLE;
      M_SERVE: return ST_SERVE;
      M_PLAY:  return ST_PLAY;
      M_PAUSE: return ST_PAUSE;
      M_POINT: return ST_POINT;
      default: return ST_GAME_OVER;
    endcase
  endfunction

  function automatic int move(input int y, input logic [3:0] k);
    if (k == 4'd2) return (y - 4 < 0) ? 0 : y - 4;
    if (k == 4'd8) return (y + 4 > 420) ? 420 : y + 4;
    return y;
  endfunction

  task automatic model_reset();
    mst = M_IDLE; msaved = M_IDLE;
    mp1 = 210; mp2 = 210; mbx = 316; mby = 236;
    ms1 = 0; ms2 = 0; mwin = 0; mpt = 0;
    mdx = 4; mdy = 0; mright = 1; mdown = 0; mserver = 1; mtimer = 0;
  endtask

  task automatic place_serve();
    if (mserver == 1) begin mbx = 25;  mby = mp1 + 26; end
    else              begin mbx = 607; mby = mp2 + 26; end
  endtask

  task automatic face_event(input int side, input int py, input int nx, input int ny);
    int c, z;
    if (ny + 8 > py && ny < py + 60) begin
      c = ny + 4 - py;
      z = (c < 0) ? 0 : c / 12;
      if (z > 4) z = 4;
      mbx = (side == 1) ? 24 : 608;
      mby = ny;
      mright = (side == 1);
      mdx = zdx[z]; mdy = zdy[z];
      if (z < 2) mdown = 0;
      else if (z > 2) mdown = 1;
    end else begin
      mbx = nx; mby = ny; mpt = 1; mst = M_POINT; mtimer = 30;
      if (side == 1) begin if (ms2 < 7) ms2++; mserver = 1; end
      else           begin if (ms1 < 7) ms1++; mserver = 2; end
    end
  endtask

  task automatic model_step(input logic rst_n, tk, st, ps, input logic [3:0] k1, k2);
    int op1, op2, nx, ny;
    if (!rst_n) begin model_reset(); return; end
    mpt = 0;
    if (st) begin
      ms1 = 0; ms2 = 0; mwin = 0; mserver = 1; mst = M_SERVE; mtimer = 60;
      place_serve();
      return;
    end
    if (ps && (mst == M_SERVE || mst == M_PLAY)) begin msaved = mst; mst = M_PAUSE; return; end
    if (ps && mst == M_PAUSE) begin mst = msaved; return; end
    if (!tk) return;
    case (mst)
      M_SERVE: begin
        mp1 = move(mp1, k1); mp2 = move(mp2, k2);
        place_serve();
        mtimer--;
        if (mtimer == 0) begin
          mst = M_PLAY; mdx = 4; mdy = 0; mright = (mserver == 1); mdown = 0;
        end
      end
      M_PLAY: begin
        op1 = mp1; op2 = mp2;
        mp1 = move(mp1, k1); mp2 = move(mp2, k2);
        nx = mbx + (mright ? mdx : -mdx);
        ny = mby + (mdown ? mdy : -mdy);
        if (ny < 0) begin ny = 0; mdown = 1; end
        else if (ny + 8 > 480) begin ny = 472; mdown = 0; end
        if (!mright && nx <= 24)     face_event(1, op1, nx, ny);
        else if (mright && nx + 8 >= 616) face_event(2, op2, nx, ny);
        else begin mbx = nx; mby = ny; end
      end
      M_POINT: begin
        mtimer--;
        if (mtimer == 0) begin
          if (ms1 == 7)      begin mst = M_OVER; mwin = 1; end
          else if (ms2 == 7) begin mst = M_OVER; mwin = 2; end
          else begin mst = M_SERVE; mtimer = 60; place_serve(); end
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ball_x", 32'(ball_x), 32'(mbx));
    chk("ball_y", 32'(ball_y), 32'(mby));
    chk("paddle_1_y", 32'(paddle_1_y), 32'(mp1));
    chk("paddle_2_y", 32'(paddle_2_y), 32'(mp2));
    chk("score_1", 32'(score_1), 32'(ms1));
    chk("score_2", 32'(score_2), 32'(ms2));
    chk("state", 32'(state), 32'(st_code(mst)));
    chk("winner", 32'(winner), 32'(mwin));
    chk("point", 32'(point), 32'(mpt));
    chk("ball_y_in_field", 32'(ball_y <= 12'd472), 32'd1);
  endtask

  task automatic cycle(input logic rst_n, tk, st, ps, input logic [3:0] k1, k2);
    reset_n = rst_n; tick = tk; start = st; pause = ps; keys_1 = k1; keys_2 = k2;
    @(posedge CLOCK_25);
    model_step(rst_n, tk, st, ps, k1, k2);
    #1;
    check_all();
  endtask

  function automatic logic [3:0] rand_key();
    case ($urandom_range(0, 3))
      0:       return 4'd2;
      1:       return 4'd8;
      2:       return 4'd0;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; keys_1 = '0; keys_2 = '0;
    model_reset();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("rst_paddle_1", 32'(paddle_1_y), 32'd210);
    chk("rst_ball_x", 32'(ball_x), 32'd316);
    chk("rst_ball_y", 32'(ball_y), 32'd236);
    chk("rst_state", 32'(state), 32'(ST_IDLE));

    // Idle: ticks, keys and pause do nothing.
    cycle(1, 1, 0, 1, KEY_UP, KEY_DOWN);
    cycle(1, 1, 0, 0, KEY_UP, KEY_DOWN);
    chk("idle_paddle_frozen", 32'(paddle_1_y), 32'd210);

    cycle(1, 0, 1, 0, 0, 0);
    chk("start_to_serve", 32'(state), 32'(ST_SERVE));
    for (int i = 0; i < 60; i++) cycle(1, 1, 0, 0, KEY_UP, 0);
    chk("p1_up_to_top", 32'(paddle_1_y), 32'd0);
    chk("serve_to_play", 32'(state), 32'(ST_PLAY));
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, KEY_UP, 0);
    chk("p1_stays_top", 32'(paddle_1_y), 32'd0);

    for (int i = 0; i < 400 && point !== 1'b1; i++) cycle(1, 1, 0, 0, 0, 0);
    chk("first_point_pulse", 32'(point), 32'd1);
    chk("first_point_score_1", 32'(score_1), 32'd1);
    chk("first_point_state", 32'(state), 32'(ST_POINT));
    cycle(1, 0, 0, 1, 0, 0);
    chk("point_one_cycle", 32'(point), 32'd0);
    for (int i = 0; i < 29; i++) cycle(1, 1, 0, 0, 0, 0);
    chk("point_hold_29", 32'(state), 32'(ST_POINT));
    cycle(1, 1, 0, 0, 0, 0);
    chk("point_to_serve", 32'(state), 32'(ST_SERVE));
    chk("serve_by_p2_x", 32'(ball_x), 32'd607);

    for (int i = 0; i < 200; i++) cycle(1, 1, 0, 0, KEY_DOWN, 0);
    chk("p1_down_to_bottom", 32'(paddle_1_y), 32'd420);

    cycle(1, 1, 0, 1, 0, 0);
    chk("pause_enter", 32'(state), 32'(ST_PAUSE));
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, KEY_UP, KEY_UP);
    cycle(1, 0, 0, 1, 0, 0);
    chk("pause_resume", 32'(state), 32'(ST_PLAY));
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);

    cycle(0, 1, 0, 0, 0, 0);
    chk("midplay_rst_state", 32'(state), 32'(ST_IDLE));
    chk("midplay_rst_score_1", 32'(score_1), 32'd0);
    chk("midplay_rst_paddle_1", 32'(paddle_1_y), 32'd210);

    // Zone 0: ball centre 6 px below the top of paddle 2.
    cycle(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 60; i++) cycle(1, 1, 0, 0, (i < 6) ? KEY_UP : 4'd0, 0);
    for (int i = 0; i < 300 && ball_x !== 12'd608; i++) cycle(1, 1, 0, 0, 0, 0);
    chk("zone0_face_clamp", 32'(ball_x), 32'd608);
    cycle(1, 1, 0, 0, 0, 0);
    chk("zone0_dx", 32'(ball_x), 32'd606);
    chk("zone0_dy_up", 32'(ball_y), 32'd210);

    // Zone 2: ball centre at the middle of paddle 2.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 60; i++) cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 300 && ball_x !== 12'd608; i++) cycle(1, 1, 0, 0, 0, 0);
    chk("zone2_face_clamp", 32'(ball_x), 32'd608);
    cycle(1, 1, 0, 0, 0, 0);
    chk("zone2_dx", 32'(ball_x), 32'd604);
    chk("zone2_dy_zero", 32'(ball_y), 32'd236);

    // Randomized play through to game over.
    for (int n = 0; n < 40000 && mst != M_OVER; n++)
      cycle(1, $urandom_range(0, 3) != 0, 0, $urandom_range(0, 1499) == 0, rand_key(), rand_key());
    chk("game_over_reached", 32'(state), 32'(ST_GAME_OVER));
    chk("game_over_winner_set", 32'(winner != 2'b00), 32'd1);

    cycle(1, 1, 0, 1, KEY_DOWN, KEY_UP);
    chk("game_over_pause_ignored", 32'(state), 32'(ST_GAME_OVER));
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, KEY_DOWN, KEY_UP);
    cycle(1, 1, 1, 1, 0, 0);
    chk("restart_state", 32'(state), 32'(ST_SERVE));
    chk("restart_score_1", 32'(score_1), 32'd0);
    chk("restart_score_2", 32'(score_2), 32'd0);
    chk("restart_winner", 32'(winner), 32'd0);
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, rand_key(), rand_key());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
